// File: rtl/sdram_write_queue.sv
// sdram_write_queue: posts CPU stores into a small circular buffer and drains
// them to the sdram wrapper's write port at a paced rate. Loads are forwarded
// from the youngest matching queued store, otherwise taken from sdram q.
// Writes are held off until the wrapper's post-reset RAM clear has finished.
module sdram_write_queue #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 8,
    parameter int DRAIN_GAP = 4,
    parameter int INIT_WAIT = 1000000
) (
    input  logic                   CLOCK_50,
    input  logic                   RESET_N,
    input  logic                   cpu_we,
    input  logic [ADDR_W-1:0]      cpu_addr,
    input  logic [DATA_W-1:0]      cpu_d,
    output logic                   cpu_ready,
    input  logic [ADDR_W-1:0]      cpu_rd_addr,
    output logic [DATA_W-1:0]      cpu_q,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level,
    output logic [ADDR_W-1:0]      write_address,
    output logic [DATA_W-1:0]      d,
    output logic                   write_en,
    output logic [ADDR_W-1:0]      read_address,
    input  logic [DATA_W-1:0]      q
);

    localparam int PW      = $clog2(DEPTH);
    localparam int CNT_MAX = (INIT_WAIT > DRAIN_GAP) ? INIT_WAIT : DRAIN_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INIT_LAST = CW'(INIT_WAIT - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((DRAIN_GAP > 0) ? DRAIN_GAP - 1 : 0);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ISSUE, S_GAP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW:0]       wr_ptr_q, wr_ptr_d;
    logic [PW:0]       rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;

    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic              full, empty, push, pop;
    logic [PW:0]       fwd_start, fwd_cnt, fwd_idx;

    // Full is judged from the registered pointers, so a same-cycle pop never frees a slot for a push.
    assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign cpu_ready = !full && (state_q != S_INIT);
    assign push      = cpu_we && cpu_ready;
    assign level     = wr_ptr_q - rd_ptr_q;

    assign overflow      = ovf_q;
    assign write_en      = we_q;
    assign write_address = wa_q;
    assign d             = wd_q;
    assign read_address  = cpu_rd_addr;

    // Drain sequencer next state: wait out the RAM clear, then issue one entry per pacing period.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        pop     = 1'b0;
        case (state_q)
            S_INIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_IDLE: begin
                if (!empty) begin
                    wa_d    = addr_mem_q[rd_ptr_q[PW-1:0]];
                    wd_d    = data_mem_q[rd_ptr_q[PW-1:0]];
                    we_d    = 1'b1;
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = (DRAIN_GAP == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // Pointer and sticky-overflow next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        if (cpu_we && !cpu_ready) ovf_d = 1'b1;
    end

    // Control and drain-port registers; reset discards everything queued.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_INIT;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            we_q     <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            we_q     <= we_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
        end
    end

    // Entry storage; slots are only meaningful between the pointers, so no reset is needed.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            addr_mem_q[wr_ptr_q[PW-1:0]] <= cpu_addr;
            data_mem_q[wr_ptr_q[PW-1:0]] <= cpu_d;
        end
    end

    // Load forwarding: scan oldest to youngest so the youngest match wins. While write_en is
    // high the entry just popped (one slot behind rd_ptr) still counts, since sdram has not
    // absorbed it yet.
    always_comb begin
        fwd_start = we_q ? (rd_ptr_q - (PW+1)'(1)) : rd_ptr_q;
        fwd_cnt   = wr_ptr_q - fwd_start;
        fwd_idx   = fwd_start;
        cpu_q     = q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = fwd_start + (PW+1)'(i);
            if (((PW+1)'(i) < fwd_cnt) && (addr_mem_q[fwd_idx[PW-1:0]] == cpu_rd_addr)) begin
                cpu_q = data_mem_q[fwd_idx[PW-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_sdram_write_queue.sv
// Bench for sdram_write_queue: scoreboard of posted stores checked against
// every write_en pulse, a table of load-forwarding vectors, and hand-written
// sequences for init hold-off, fill/overflow, wrap and mid-run reset.
module tb_sdram_write_queue;

    localparam int ADDR_W    = 13;
    localparam int DATA_W    = 16;
    localparam int DEPTH     = 8;
    localparam int DRAIN_GAP = 20;
    localparam int INIT_WAIT = 16;
    localparam int LW        = $clog2(DEPTH) + 1;

    logic              clk;
    logic              RESET_N;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_d;
    logic              cpu_ready;
    logic [ADDR_W-1:0] cpu_rd_addr;
    logic [DATA_W-1:0] cpu_q;
    logic              overflow;
    logic [LW-1:0]     level;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] d;
    logic              write_en;
    logic [ADDR_W-1:0] read_address;
    logic [DATA_W-1:0] q;

    sdram_write_queue #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .DRAIN_GAP(DRAIN_GAP), .INIT_WAIT(INIT_WAIT)
    ) dut (
        .CLOCK_50(clk), .RESET_N(RESET_N), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_d(cpu_d), .cpu_ready(cpu_ready), .cpu_rd_addr(cpu_rd_addr), .cpu_q(cpu_q),
        .overflow(overflow), .level(level), .write_address(write_address), .d(d),
        .write_en(write_en), .read_address(read_address), .q(q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] dat;
    } ent_t;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] qin;
        logic [DATA_W-1:0] exp;
    } vec_t;

    ent_t sb[$];
    vec_t tbl[6];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_pulse = 0;
    bit   last_valid = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock; outputs are sampled 1ns after the edge. Every write_en pulse is
    // matched against the oldest posted store and the pacing is checked.
    task automatic tick();
        ent_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (!RESET_N) begin
            last_valid = 0;
        end else if (write_en) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr=0x%0h data=0x%0h with nothing queued", write_address, d);
            end else begin
                e = sb.pop_front();
                chk("drain_addr", 32'(write_address), 32'(e.a));
                chk("drain_data", 32'(d), 32'(e.dat));
            end
            if (last_valid) begin
                checks++;
                if (cyc - last_pulse < DRAIN_GAP + 2) begin
                    errors++;
                    $display("FAIL pulse_gap: got %0d cycles required at least %0d", cyc - last_pulse, DRAIN_GAP + 2);
                end
            end
            last_pulse = cyc;
            last_valid = 1;
        end
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
        chk("push_ready", 32'(cpu_ready), 32'd1);
        cpu_we   = 1'b1;
        cpu_addr = a;
        cpu_d    = v;
        sb.push_back('{a: a, dat: v});
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic wait_we(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (write_en) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_write_en: no pulse within %0d cycles", budget);
        end
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        cpu_we  = 1'b0;
        sb.delete();
        tick();
        tick();
    endtask

    task automatic reset_and_init();
        do_reset();
        RESET_N = 1'b1;
        for (int k = 0; k < INIT_WAIT; k++) tick();
    endtask

    int  t0, t1, t2;
    bit  seen;

    initial begin
        tbl[0] = '{rd: 13'h0005, qin: 16'hAAAA, exp: 16'h2222};
        tbl[1] = '{rd: 13'h0009, qin: 16'hAAAA, exp: 16'h3333};
        tbl[2] = '{rd: 13'h0007, qin: 16'h0BAD, exp: 16'h0BAD};
        tbl[3] = '{rd: 13'h0000, qin: 16'h1357, exp: 16'h1357};
        tbl[4] = '{rd: 13'h1FFF, qin: 16'h2468, exp: 16'h2468};
        tbl[5] = '{rd: 13'h0005, qin: 16'hFFFF, exp: 16'h2222};

        RESET_N     = 1'b1;
        cpu_we      = 1'b0;
        cpu_addr    = '0;
        cpu_d       = '0;
        cpu_rd_addr = '0;
        q           = '0;
        #2;

        // Reset state, INIT hold-off and drop-with-overflow during INIT
        do_reset();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ready", 32'(cpu_ready), 32'd0);
        chk("rst_write_en", 32'(write_en), 32'd0);
        chk("rst_write_address", 32'(write_address), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        RESET_N = 1'b1;
        for (int k = 1; k <= INIT_WAIT; k++) begin
            tick();
            if (k == 5) begin
                cpu_we = 1'b1; cpu_addr = 13'h0055; cpu_d = 16'h5555;
                chk("init_ready_c5", 32'(cpu_ready), 32'd0);
            end
            if (k == 6) begin
                cpu_we = 1'b0;
                chk("init_overflow", 32'(overflow), 32'd1);
                chk("init_level", 32'(level), 32'd0);
            end
            if (k == INIT_WAIT - 1) chk("init_ready_last", 32'(cpu_ready), 32'd0);
            if (k == INIT_WAIT) chk("idle_ready", 32'(cpu_ready), 32'd1);
        end

        // Single store latency and drain pacing
        push(13'h0010, 16'hBEEF);
        chk("lat_no_pulse_yet", 32'(write_en), 32'd0);
        tick();
        chk("lat_write_en", 32'(write_en), 32'd1);
        chk("lat_write_address", 32'(write_address), 32'h0010);
        chk("lat_d", 32'(d), 32'hBEEF);
        t0 = cyc;
        push(13'h0011, 16'h1111);
        push(13'h0012, 16'h1212);
        chk("hold_write_en", 32'(write_en), 32'd0);
        chk("hold_write_address", 32'(write_address), 32'h0010);
        chk("hold_d", 32'(d), 32'hBEEF);
        wait_we(DRAIN_GAP + 10);
        t1 = cyc;
        chk("spacing_1", 32'(t1 - t0), 32'(DRAIN_GAP + 2));
        wait_we(DRAIN_GAP + 10);
        t2 = cyc;
        chk("spacing_2", 32'(t2 - t1), 32'(DRAIN_GAP + 2));

        // Fill to DEPTH behind a leader, refuse at full, refuse at the pop edge, then wrap
        reset_and_init();
        push(13'h01F0, 16'h0F0F);
        wait_we(5);
        for (int i = 0; i < DEPTH; i++) push(13'(i), 16'hA000 + 16'(i));
        chk("full_level", 32'(level), 32'(DEPTH));
        chk("full_ready", 32'(cpu_ready), 32'd0);
        chk("full_overflow_clear", 32'(overflow), 32'd0);
        cpu_we = 1'b1; cpu_addr = 13'h0008; cpu_d = 16'hA008;
        tick();
        cpu_we = 1'b0;
        chk("ninth_overflow", 32'(overflow), 32'd1);
        chk("ninth_level", 32'(level), 32'(DEPTH));
        cpu_we = 1'b1; cpu_addr = 13'h01FF; cpu_d = 16'hDEAD;
        seen = 0;
        for (int i = 0; i < DRAIN_GAP + 10; i++) begin
            tick();
            if (write_en) begin
                seen = 1;
                break;
            end
        end
        cpu_we = 1'b0;
        chk("poppush_seen", 32'(seen), 32'd1);
        chk("poppush_level", 32'(level), 32'(DEPTH - 1));
        chk("poppush_overflow", 32'(overflow), 32'd1);
        for (int n = 0; n < 3 * DEPTH; n++) begin
            for (int w = 0; w < 4 * (DRAIN_GAP + 2) && !cpu_ready; w++) tick();
            push(13'h0040 + 13'(n), 16'($urandom));
        end
        for (int w = 0; w < 20 * (DRAIN_GAP + 2) && sb.size() != 0; w++) tick();
        chk("wrap_drained", 32'(sb.size()), 32'd0);
        for (int w = 0; w < DRAIN_GAP + 4; w++) tick();
        chk("wrap_level", 32'(level), 32'd0);

        // Load forwarding
        reset_and_init();
        q = 16'hAAAA; cpu_rd_addr = 13'h0005;
        #1;
        chk("fwd_empty", 32'(cpu_q), 32'hAAAA);
        cpu_we = 1'b1; cpu_addr = 13'h0005; cpu_d = 16'h1111;
        sb.push_back('{a: 13'h0005, dat: 16'h1111});
        #1;
        chk("fwd_same_cycle_push", 32'(cpu_q), 32'hAAAA);
        tick();
        cpu_we = 1'b0;
        chk("fwd_first", 32'(cpu_q), 32'h1111);
        push(13'h0005, 16'h2222);
        chk("fwd_youngest", 32'(cpu_q), 32'h2222);
        push(13'h0009, 16'h3333);
        for (int i = 0; i < 6; i++) begin
            cpu_rd_addr = tbl[i].rd;
            q           = tbl[i].qin;
            #1;
            chk($sformatf("fwd_vec%0d", i), 32'(cpu_q), 32'(tbl[i].exp));
            chk($sformatf("rd_addr_vec%0d", i), 32'(read_address), 32'(tbl[i].rd));
            tick();
        end
        q = 16'hAAAA; cpu_rd_addr = 13'h0005;
        wait_we(DRAIN_GAP + 10);
        chk("fwd_popped_2222", 32'(cpu_q), 32'h2222);
        tick();
        chk("fwd_after_pop", 32'(cpu_q), 32'hAAAA);
        cpu_rd_addr = 13'h0009;
        #1;
        chk("fwd_3333", 32'(cpu_q), 32'h3333);
        wait_we(DRAIN_GAP + 10);
        chk("fwd_popped_3333", 32'(cpu_q), 32'h3333);
        tick();
        chk("fwd_follows_q", 32'(cpu_q), 32'hAAAA);

        // Reset mid-operation with 5 entries queued
        reset_and_init();
        for (int i = 0; i < 7; i++) push(13'h0300 + 13'(i), 16'h3000 + 16'(i));
        wait_we(DRAIN_GAP + 10);
        chk("mid_level_before", 32'(level), 32'd5);
        #1;
        RESET_N = 1'b0;
        #1;
        chk("mid_write_en", 32'(write_en), 32'd0);
        chk("mid_level", 32'(level), 32'd0);
        chk("mid_ready", 32'(cpu_ready), 32'd0);
        sb.delete();
        tick();
        tick();
        RESET_N = 1'b1;
        for (int k = 0; k < INIT_WAIT + 3 * (DRAIN_GAP + 2); k++) tick();
        chk("post_level", 32'(level), 32'd0);
        chk("post_overflow", 32'(overflow), 32'd0);
        chk("post_write_address", 32'(write_address), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
